memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-fetch requester (I, read-only, block fills) and the MEM-stage data requester (D, read/write, block fills and write-backs).
- Sequences each transaction: grant, hold, complete, release. It also stalls the losing requester through its BUSYWAIT.
- D has priority because it belongs to the older instruction. A bounded starvation counter guarantees forward progress for I.

Parameters:
- ADDR_W, 28, block address width
- DATA_W, 128, block data width
- MAX_CONSEC, 4, maximum consecutive D grants while I is waiting; range 1..15

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- I_READ  in  1  instruction-side read request, level
- I_ADDRESS  in  ADDR_W  instruction-side block address
- I_READDATA  out  DATA_W  instruction-side read data
- I_BUSYWAIT  out  1  stall to the instruction side
- D_READ  in  1  data-side read request
- D_WRITE  in  1  data-side write request
- D_ADDRESS  in  ADDR_W  data-side block address
- D_WRITEDATA  in  DATA_W  data-side write block
- D_READDATA  out  DATA_W  data-side read data
- D_BUSYWAIT  out  1  stall to the data side
- M_READ  out  1  memory read strobe
- M_WRITE  out  1  memory write strobe
- M_ADDRESS  out  ADDR_W  memory address
- M_WRITEDATA  out  DATA_W  memory write data
- M_READDATA  in  DATA_W  memory read data
- M_BUSYWAIT  in  1  memory busy

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous, active-high.
- On reset: state=IDLE; M_READ=0, M_WRITE=0; M_ADDRESS=0, M_WRITEDATA=0; consec_cnt=0.
- Reset mid-transaction abandons it. The memory sees its strobe drop immediately.
- Requester contract: the request is held high, with address and data stable, until the first rising edge at which its BUSYWAIT=0.
- Memory contract: M_BUSYWAIT goes high in the same cycle a strobe is raised. It stays high until data is ready or the write is done.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, arbitration:
  - D request = D_READ|D_WRITE.
  - If only D requests -> SERVE_D. If only I requests -> SERVE_I.
  - If both request: consec_cnt<MAX_CONSEC -> SERVE_D; otherwise -> SERVE_I.
  - If neither requests -> stay in IDLE.
- Grant edge: M_ADDRESS, M_WRITEDATA and the op are captured into registers from the winner.
- If D_READ and D_WRITE are both high, the op is WRITE and the read is ignored.
- Strobes are registered: M_READ/M_WRITE are high for every cycle in SERVE_x, and low in IDLE and RELEASE.
- Grant latency: a request seen in IDLE at cycle n gives a strobe at cycle n+1.
- Completion cycle: any SERVE_x cycle with M_BUSYWAIT=0. That is never the first SERVE cycle under the memory contract, but the arbiter does not rely on this.
  - On the completion edge: -> RELEASE.
- RELEASE: lasts exactly one cycle with strobes low, then -> IDLE. Back-to-back transactions are therefore separated by 2 idle-strobe cycles.
- I_BUSYWAIT = I_READ & !(state==SERVE_I & !M_BUSYWAIT). This is combinational.
- D_BUSYWAIT = (D_READ|D_WRITE) & !(state==SERVE_D & !M_BUSYWAIT). This is combinational.
- A request still high in RELEASE or IDLE is a new request, and BUSYWAIT stays high.
- Read data: I_READDATA = D_READDATA = M_READDATA, passed through. It is valid only in the owner's completion cycle.
- consec_cnt, updated at the grant edge:
  - D granted while I_READ=1: increment, saturating at MAX_CONSEC.
  - D granted while I_READ=0: clear to 0.
  - I granted: clear to 0.
- Bound: I waits at most MAX_CONSEC D transactions.
- The non-granted requester cannot affect M_* during a transaction. Address changes by the owner after the grant are ignored because the values are captured.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10, RELEASE=2'b11);
  - op encoding constants (OP_READ, OP_WRITE);
  - the default ADDR_W/DATA_W.
- One natural sub-module: arb_starvation_counter. It takes inc, clr and MAX_CONSEC and outputs force_i. It has its own asynchronous reset to 0.

Test Plan:
- Reset, then I_READ=1 at address 0x0000010 with a 3-cycle memory:
  - M_READ rises 1 cycle after the request, with M_ADDRESS=0x0000010.
  - I_BUSYWAIT falls in the completion cycle, with I_READDATA=memory block.
  - M_READ is low during RELEASE.
- I_READ and D_WRITE rise in the same IDLE cycle:
  - D is served first: M_WRITE=1 with D_WRITEDATA, and I_BUSYWAIT stays 1.
  - After D completes plus RELEASE and IDLE, I is served.
- I_READ is held high while D issues 6 back-to-back requests with MAX_CONSEC=4:
  - The grant order is D,D,D,D,I,D,D.
  - consec_cnt reads 4 before the I grant and 0 after it.
- D_READ=1 and D_WRITE=1 at the same time -> M_WRITE=1 and M_READ=0 throughout SERVE_D.
- RESET is asserted in the 2nd cycle of SERVE_D:
  - M_WRITE drops in the same cycle, asynchronously; state=IDLE and consec_cnt=0.
  - With the request still high, M_WRITE reasserts 1 cycle after RESET releases.
- Memory with M_BUSYWAIT already 0 in the first SERVE cycle -> the transaction completes in 1 cycle, and RELEASE still occurs.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding, op codes,
// default bus widths.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 28;
  localparam int unsigned DEF_DATA_W = 128;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10,
    RELEASE = 2'b11
  } arb_state_e;

  function automatic logic is_serve(input arb_state_e s);
    return (s == SERVE_I) || (s == SERVE_D);
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// master = arbiter view, slave = environment (requesters + memory) view.
interface memory_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              M_READ;
  logic              M_WRITE;
  logic [ADDR_W-1:0] M_ADDRESS;
  logic [DATA_W-1:0] M_WRITEDATA;
  logic [DATA_W-1:0] M_READDATA;
  logic              M_BUSYWAIT;

  modport master (
    input  I_READ, I_ADDRESS,
    output I_READDATA, I_BUSYWAIT,
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output D_READDATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    input  M_READDATA, M_BUSYWAIT
  );

  modport slave (
    output I_READ, I_ADDRESS,
    input  I_READDATA, I_BUSYWAIT,
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  D_READDATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    output M_READDATA, M_BUSYWAIT
  );

endinterface

// File: rtl/memory_port_arbiter_starvation_counter.sv
// Counts consecutive D grants taken while I waits; o_force_i hands the next
// contested grant to I once the limit is reached.
module arb_starvation_counter #(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_force_i
);

  localparam logic [3:0] MaxCnt = 4'(MAX_CONSEC);

  logic [3:0] r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < MaxCnt)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_force_i = (r_cnt >= MaxCnt);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch (I) and
// the MEM-stage data side (D); D wins unless I has been starved MAX_CONSEC times.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  memory_port_arbiter_if.master bus
);

  arb_state_e r_state, w_state_next;

  logic              r_m_read;
  logic              r_m_write;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;

  logic w_d_req, w_force_i, w_grant_d, w_grant_i, w_done, w_d_op;

  assign w_d_req   = bus.D_READ | bus.D_WRITE;
  assign w_grant_d = (r_state == IDLE) && w_d_req && !(bus.I_READ && w_force_i);
  assign w_grant_i = (r_state == IDLE) && bus.I_READ && !w_grant_d;
  assign w_done    = is_serve(r_state) && !bus.M_BUSYWAIT;
  // A simultaneous read+write request is treated as a write.
  assign w_d_op    = bus.D_WRITE ? OP_WRITE : OP_READ;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d)      w_state_next = SERVE_D;
        else if (w_grant_i) w_state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (w_done) w_state_next = RELEASE;
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Everything driven to memory is captured at the grant edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else if (w_grant_d) begin
      r_m_read  <= (w_d_op == OP_READ);
      r_m_write <= (w_d_op == OP_WRITE);
      r_m_addr  <= bus.D_ADDRESS;
      r_m_wdata <= bus.D_WRITEDATA;
    end else if (w_grant_i) begin
      r_m_read  <= 1'b1;
      r_m_write <= 1'b0;
      r_m_addr  <= bus.I_ADDRESS;
      r_m_wdata <= '0;
    end else if (w_done) begin
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
    end
  end

  arb_starvation_counter #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_starv (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_inc    (w_grant_d && bus.I_READ),
    .i_clr    ((w_grant_d && !bus.I_READ) || w_grant_i),
    .o_force_i(w_force_i)
  );

  assign bus.M_READ      = r_m_read;
  assign bus.M_WRITE     = r_m_write;
  assign bus.M_ADDRESS   = r_m_addr;
  assign bus.M_WRITEDATA = r_m_wdata;

  assign bus.I_BUSYWAIT = bus.I_READ & !((r_state == SERVE_I) & !bus.M_BUSYWAIT);
  assign bus.D_BUSYWAIT = w_d_req & !((r_state == SERVE_D) & !bus.M_BUSYWAIT);

  assign bus.I_READDATA = bus.M_READDATA;
  assign bus.D_READDATA = bus.M_READDATA;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench: directed scenarios queue expected grants/completions,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_memory_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   cnt;
  } grant_t;

  typedef struct {
    logic          side_d;
    logic          rd;
    logic [DW-1:0] data;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int unsigned mem_lat = 3;
  int unsigned mem_cnt;
  logic prev_strobe = 1'b0;
  grant_t gq[$];
  done_t  cq[$];

  always #5 clk = ~clk;

  memory_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  memory_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_CONSEC(4)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus_if)
  );

  function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  // Memory model: busy from the first strobe cycle for mem_lat cycles.
  always_ff @(posedge clk) begin
    if (bus_if.M_READ || bus_if.M_WRITE) mem_cnt <= mem_cnt + 1;
    else                                 mem_cnt <= 0;
  end
  assign bus_if.M_BUSYWAIT = (bus_if.M_READ || bus_if.M_WRITE) && (mem_cnt < mem_lat);
  assign bus_if.M_READDATA = blk(bus_if.M_ADDRESS);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    logic   strobe;
    grant_t g;
    done_t  c;
    strobe = bus_if.M_READ | bus_if.M_WRITE;
    if (!rst) begin
      if (strobe && !prev_strobe) begin
        if (gq.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          g = gq.pop_front();
          chk("grant_write", DW'(bus_if.M_WRITE), DW'(g.wr));
          chk("grant_read", DW'(bus_if.M_READ), DW'(!g.wr));
          chk("grant_addr", DW'(bus_if.M_ADDRESS), DW'(g.addr));
          if (g.wr) chk("grant_wdata", bus_if.M_WRITEDATA, g.wdata);
          chk("consec_cnt", DW'(dut.u_starv.r_cnt), DW'(g.cnt));
        end
      end
      if (strobe) chk("strobe_excl", DW'(bus_if.M_READ & bus_if.M_WRITE), DW'(0));
      if (dut.r_state == RELEASE) chk("release_strobe", DW'(strobe), DW'(0));
      if (dut.r_state == SERVE_D && bus_if.I_READ) chk("i_stall", DW'(bus_if.I_BUSYWAIT), DW'(1));
      if (bus_if.I_READ && !bus_if.I_BUSYWAIT) begin
        if (cq.size() == 0) fail_now("unexpected_i_done");
        else begin
          c = cq.pop_front();
          chk("i_done_side", DW'(c.side_d), DW'(0));
          chk("i_rdata", bus_if.I_READDATA, c.data);
        end
      end
      if ((bus_if.D_READ || bus_if.D_WRITE) && !bus_if.D_BUSYWAIT) begin
        if (cq.size() == 0) fail_now("unexpected_d_done");
        else begin
          c = cq.pop_front();
          chk("d_done_side", DW'(c.side_d), DW'(1));
          if (c.rd) chk("d_rdata", bus_if.D_READDATA, c.data);
        end
      end
    end
    prev_strobe = strobe;
  end

  task automatic i_txn(input logic [AW-1:0] a);
    bus_if.I_READ    = 1'b1;
    bus_if.I_ADDRESS = a;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus_if.I_BUSYWAIT) begin
        @(posedge clk);
        #1;
        bus_if.I_READ = 1'b0;
        return;
      end
    end
    fail_now("i_timeout");
    bus_if.I_READ = 1'b0;
  endtask

  task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    bus_if.D_READ      = rd;
    bus_if.D_WRITE     = wr;
    bus_if.D_ADDRESS   = a;
    bus_if.D_WRITEDATA = wd;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus_if.D_BUSYWAIT) begin
        @(posedge clk);
        #1;
        bus_if.D_READ  = 1'b0;
        bus_if.D_WRITE = 1'b0;
        return;
      end
    end
    fail_now("d_timeout");
    bus_if.D_READ  = 1'b0;
    bus_if.D_WRITE = 1'b0;
  endtask

  task automatic push_g(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int unsigned cnt);
    grant_t g;
    g.wr = wr; g.addr = a; g.wdata = wd; g.cnt = cnt;
    gq.push_back(g);
  endtask

  task automatic push_c(input logic side_d, input logic rd, input logic [DW-1:0] d);
    done_t c;
    c.side_d = side_d; c.rd = rd; c.data = d;
    cq.push_back(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_if.I_READ = 1'b0;
    bus_if.I_ADDRESS = '0;
    bus_if.D_READ = 1'b0;
    bus_if.D_WRITE = 1'b0;
    bus_if.D_ADDRESS = '0;
    bus_if.D_WRITEDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", DW'(dut.r_state), DW'(IDLE));
    chk("rst_mread", DW'(bus_if.M_READ), DW'(0));
    chk("rst_mwrite", DW'(bus_if.M_WRITE), DW'(0));
    chk("rst_maddr", DW'(bus_if.M_ADDRESS), DW'(0));
    chk("rst_mwdata", bus_if.M_WRITEDATA, DW'(0));
    chk("rst_cnt", DW'(dut.u_starv.r_cnt), DW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // I read, 3-cycle memory
    mem_lat = 3;
    push_g(1'b0, 28'h0000010, '0, 0);
    push_c(1'b0, 1'b1, blk(28'h0000010));
    fork
      i_txn(28'h0000010);
      begin
        @(posedge clk);
        #1;
        chk("s1_mread_latency", DW'(bus_if.M_READ), DW'(1));
        chk("s1_maddr", DW'(bus_if.M_ADDRESS), DW'(28'h0000010));
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // I and D raised together: D first
    mem_lat = 2;
    push_g(1'b1, 28'h0000020, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444, 1);
    push_g(1'b0, 28'h0000030, '0, 0);
    push_c(1'b1, 1'b0, '0);
    push_c(1'b0, 1'b1, blk(28'h0000030));
    fork
      i_txn(28'h0000030);
      d_txn(1'b0, 1'b1, 28'h0000020, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444);
    join
    repeat (3) @(posedge clk);
    #1;

    // Starvation bound: D,D,D,D,I,D,D
    mem_lat = 1;
    for (int k = 0; k < 4; k++) begin
      push_g(k[0], AW'(32'h40 + k), DW'(32'hD000_0000 + k), k + 1);
      push_c(1'b1, !k[0], blk(AW'(32'h40 + k)));
    end
    push_g(1'b0, 28'h0000050, '0, 0);
    push_c(1'b0, 1'b1, blk(28'h0000050));
    for (int k = 4; k < 6; k++) begin
      push_g(k[0], AW'(32'h40 + k), DW'(32'hD000_0000 + k), 0);
      push_c(1'b1, !k[0], blk(AW'(32'h40 + k)));
    end
    fork
      i_txn(28'h0000050);
      for (int k = 0; k < 6; k++) d_txn(!k[0], k[0], AW'(32'h40 + k), DW'(32'hD000_0000 + k));
    join
    repeat (3) @(posedge clk);
    #1;

    // D_READ and D_WRITE together -> write
    mem_lat = 2;
    push_g(1'b1, 28'h0000060, 128'h6666, 0);
    push_c(1'b1, 1'b0, '0);
    d_txn(1'b1, 1'b1, 28'h0000060, 128'h6666);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the 2nd SERVE_D cycle
    mem_lat = 3;
    push_g(1'b1, 28'h0000070, 128'h7777, 0);
    push_g(1'b1, 28'h0000070, 128'h7777, 0);
    push_c(1'b1, 1'b0, '0);
    fork
      d_txn(1'b0, 1'b1, 28'h0000070, 128'h7777);
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_mwrite_drop", DW'(bus_if.M_WRITE), DW'(0));
        chk("s5_state", DW'(dut.r_state), DW'(IDLE));
        chk("s5_cnt", DW'(dut.u_starv.r_cnt), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s5_mwrite_reassert", DW'(bus_if.M_WRITE), DW'(1));
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Zero-latency memory: 1-cycle serve, RELEASE still present
    mem_lat = 0;
    push_g(1'b0, 28'h0000090, '0, 0);
    push_c(1'b0, 1'b1, blk(28'h0000090));
    fork
      i_txn(28'h0000090);
      begin
        @(posedge clk);
        #1;
        chk("s6_serve", DW'(dut.r_state), DW'(SERVE_I));
        @(posedge clk);
        #1;
        chk("s6_release", DW'(dut.r_state), DW'(RELEASE));
        chk("s6_mread_low", DW'(bus_if.M_READ), DW'(0));
      end
    join
    repeat (3) @(posedge clk);
    #1;

    chk("grant_queue_empty", DW'(gq.size()), DW'(0));
    chk("done_queue_empty", DW'(cq.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
